// File: rtl/beamform_power_trigger_if.sv
// Stream, threshold-staging and trigger bundle for beamform_power_trigger.
// The master drives samples and thresholds; the slave returns per-beam triggers.
interface beamform_power_trigger_if #(
    parameter int NBEAMS = 2
);
    logic [7:0][39:0]  data_i;
    logic [17:0]       thresh_i;
    logic [NBEAMS-1:0] thresh_ce_i;
    logic              update_i;
    logic [NBEAMS-1:0] trigger_o;

    modport master (
        output data_i,
        output thresh_i,
        output thresh_ce_i,
        output update_i,
        input  trigger_o
    );

    modport slave (
        input  data_i,
        input  thresh_i,
        input  thresh_ce_i,
        input  update_i,
        output trigger_o
    );
endinterface

// File: rtl/beamform_power_trigger.sv
// Delay-and-sum beamformer with 8-sample power and per-beam threshold trigger.
// Pipeline: input/history, beam sums, squares, power, compare (4-clock latency).
module beamform_power_trigger #(
    parameter int NBEAMS = 2,
    parameter logic [NBEAMS-1:0][7:0][3:0] BEAM_DELAYS = 64'h76543210_00000000
) (
    input logic clk_i,
    input logic rst_ni,
    beamform_power_trigger_if.slave bus
);

    typedef logic [7:0][39:0] blk_t;

    blk_t cur_q;
    blk_t h1_q;
    blk_t h2_q;

    logic [7:0][119:0] win;

    logic [NBEAMS-1:0][7:0][7:0]  sum_d;
    logic [NBEAMS-1:0][7:0][7:0]  sum_q;
    logic [NBEAMS-1:0][7:0][14:0] sq_d;
    logic [NBEAMS-1:0][7:0][14:0] sq_q;
    logic [NBEAMS-1:0][17:0]      pw_d;
    logic [NBEAMS-1:0][17:0]      pw_q;
    logic [NBEAMS-1:0][17:0]      stg_q;
    logic [NBEAMS-1:0][17:0]      act_q;
    logic [NBEAMS-1:0]            trig_q;

    // Window index j: 0..7 two clocks back, 16..23 the current clock.
    function automatic logic [7:0] sext(input logic [119:0] w, input int j);
        logic [4:0] v;
        v = w[5*j +: 5];
        return {{3{v[4]}}, v};
    endfunction

    function automatic logic [14:0] sqr(input logic [7:0] v);
        logic signed [15:0] p;
        p = signed'(v) * signed'(v);
        return p[14:0];
    endfunction

    for (genvar ch = 0; ch < 8; ch++) begin : g_win
        assign win[ch] = {cur_q[ch], h1_q[ch], h2_q[ch]};
    end

    // Beam sums wrap modulo 256; the true range -128..120 always fits.
    always_comb begin
        sum_d = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            for (int s = 0; s < 8; s++) begin
                for (int ch = 0; ch < 8; ch++) begin
                    sum_d[b][s] = sum_d[b][s]
                        + sext(win[ch], 16 + s - int'(BEAM_DELAYS[b][ch]));
                end
            end
        end
    end

    always_comb begin
        sq_d = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            for (int s = 0; s < 8; s++) begin
                sq_d[b][s] = sqr(sum_q[b][s]);
            end
        end
    end

    always_comb begin
        pw_d = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            for (int s = 0; s < 8; s++) begin
                pw_d[b] = pw_d[b] + 18'(sq_q[b][s]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q  <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            sum_q  <= '0;
            sq_q   <= '0;
            pw_q   <= '0;
            trig_q <= '0;
        end else begin
            cur_q <= bus.data_i;
            h1_q  <= cur_q;
            h2_q  <= h1_q;
            sum_q <= sum_d;
            sq_q  <= sq_d;
            pw_q  <= pw_d;
            for (int b = 0; b < NBEAMS; b++) begin
                trig_q[b] <= pw_q[b] > act_q[b];
            end
        end
    end

    // Update copies the staged value held before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q <= '1;
            act_q <= '1;
        end else begin
            for (int b = 0; b < NBEAMS; b++) begin
                if (bus.thresh_ce_i[b]) stg_q[b] <= bus.thresh_i;
                if (bus.update_i)       act_q[b] <= stg_q[b];
            end
        end
    end

    assign bus.trigger_o = trig_q;

endmodule

// File: tb/tb_beamform_power_trigger.sv
// Bench for beamform_power_trigger: directed vectors, corner sequences and
// random stream against a sample-level reference model.
module tb_beamform_power_trigger;

    typedef logic [7:0][39:0] blk_t;

    typedef struct {
        int         v;
        int         t0;
        int         t1;
        logic [1:0] exp;
    } vec_t;

    typedef struct {
        int p0;
        int p1;
    } pw_t;

    logic clk;
    logic rst_n;

    beamform_power_trigger_if #(.NBEAMS(2)) bus ();

    beamform_power_trigger dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   hist [8][24];
    int   stg  [2];
    int   act  [2];
    pw_t  pq   [$];
    logic [1:0] exp_trig;

    vec_t vecs [6];

    function automatic int dly(input int b, input int ch);
        return (b == 0) ? 0 : ch;
    endfunction

    function automatic blk_t cdata(input int v);
        blk_t d;
        for (int ch = 0; ch < 8; ch++)
            for (int s = 0; s < 8; s++)
                d[ch][5*s +: 5] = 5'(v);
        return d;
    endfunction

    task automatic chk(input string name, input logic [1:0] a, input logic [1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 8; ch++)
            for (int j = 0; j < 24; j++)
                hist[ch][j] = 0;
        stg[0] = 'h3FFFF;
        stg[1] = 'h3FFFF;
        act[0] = 'h3FFFF;
        act[1] = 'h3FFFF;
        pq.delete();
        for (int i = 0; i < 4; i++) pq.push_back('{0, 0});
        exp_trig = '0;
    endtask

    // One rising edge of the reference: power from the sample stream,
    // delayed 4 clocks, compared against the pre-edge active threshold.
    task automatic model_edge(input blk_t d, input int th,
                              input logic [1:0] ce, input logic up);
        logic signed [4:0] x;
        int p [2];
        int bs;
        pw_t old;
        for (int ch = 0; ch < 8; ch++)
            for (int s = 0; s < 8; s++) begin
                x = d[ch][5*s +: 5];
                hist[ch][16+s] = int'(x);
            end
        for (int b = 0; b < 2; b++) begin
            p[b] = 0;
            for (int s = 0; s < 8; s++) begin
                bs = 0;
                for (int ch = 0; ch < 8; ch++)
                    bs += hist[ch][16 + s - dly(b, ch)];
                p[b] += bs * bs;
            end
        end
        pq.push_back('{p[0], p[1]});
        old = pq.pop_front();
        exp_trig[0] = old.p0 > act[0];
        exp_trig[1] = old.p1 > act[1];
        if (up) begin
            act[0] = stg[0];
            act[1] = stg[1];
        end
        for (int b = 0; b < 2; b++)
            if (ce[b]) stg[b] = th;
        for (int ch = 0; ch < 8; ch++)
            for (int j = 0; j < 16; j++)
                hist[ch][j] = hist[ch][j+8];
    endtask

    task automatic step(input blk_t d, input logic [17:0] th,
                        input logic [1:0] ce, input logic up);
        bus.data_i      = d;
        bus.thresh_i    = th;
        bus.thresh_ce_i = ce;
        bus.update_i    = up;
        @(posedge clk);
        model_edge(d, int'(th), ce, up);
        #1;
        chk("model", bus.trigger_o, exp_trig);
        bus.thresh_ce_i = '0;
        bus.update_i    = 1'b0;
    endtask

    task automatic run(input int n, input blk_t d);
        for (int i = 0; i < n; i++) step(d, '0, 2'b00, 1'b0);
    endtask

    task automatic load(input blk_t d, input int t0, input int t1);
        step(d, 18'(t0), 2'b01, 1'b0);
        step(d, 18'(t1), 2'b10, 1'b0);
        step(d, '0, 2'b00, 1'b1);
    endtask

    initial begin
        blk_t z;
        blk_t one;
        blk_t al;
        blk_t rd;
        logic [1:0] e;

        vecs[0] = '{1,    100,    'h3FFFF, 2'b01};
        vecs[1] = '{1,    512,    'h3FFFF, 2'b00};
        vecs[2] = '{1,    511,    511,     2'b11};
        vecs[3] = '{-16,  131071, 131071,  2'b11};
        vecs[4] = '{-16,  131072, 0,       2'b10};
        vecs[5] = '{2,    2047,   2048,    2'b01};

        z   = cdata(0);
        one = cdata(1);

        rst_n           = 1'b0;
        bus.data_i      = z;
        bus.thresh_i    = '0;
        bus.thresh_ce_i = '0;
        bus.update_i    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", bus.trigger_o, 2'b00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            load(cdata(vecs[i].v), vecs[i].t0, vecs[i].t1);
            run(6, cdata(vecs[i].v));
            chk($sformatf("vec%0d", i), bus.trigger_o, vecs[i].exp);
        end

        // Async reset while triggers are active, then threshold 0 on zero data.
        load(one, 0, 0);
        run(6, one);
        chk("pre_reset", bus.trigger_o, 2'b11);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", bus.trigger_o, 2'b00);
        @(posedge clk);
        #1 chk("reset_hold", bus.trigger_o, 2'b00);
        rst_n = 1'b1;
        model_reset();
        load(z, 0, 0);
        run(8, z);
        chk("zero_power", bus.trigger_o, 2'b00);

        // Staging: ce alone never reaches active; ce+update takes the old stage.
        load(one, 0, 'h3FFFF);
        run(6, one);
        chk("stage_base", bus.trigger_o, 2'b01);
        step(one, 18'd0, 2'b10, 1'b0);
        run(6, one);
        chk("stage_no_upd", bus.trigger_o, 2'b01);
        step(one, 18'h3FFFF, 2'b10, 1'b1);
        run(6, one);
        chk("stage_same_edge", bus.trigger_o, 2'b11);
        step(one, '0, 2'b00, 1'b1);
        run(6, one);
        chk("stage_late_upd", bus.trigger_o, 2'b01);

        // Delay alignment pulse.
        al = z;
        for (int ch = 0; ch < 8; ch++) al[ch][5*(7-ch) +: 5] = 5'd1;
        load(z, 32, 32);
        run(4, z);
        step(al, '0, 2'b00, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(z, '0, 2'b00, 1'b0);
            chk($sformatf("align_%0d", i), bus.trigger_o,
                (i == 4) ? 2'b10 : 2'b00);
        end

        // Alternating power: beam0 toggles every clock, 4 clocks late.
        load(z, 0, 'h3FFFF);
        run(3, z);
        for (int j = 0; j < 12; j++) begin
            step((j % 2 == 0) ? one : z, '0, 2'b00, 1'b0);
            if (j >= 4) begin
                e = ((j - 4) % 2 == 0) ? 2'b01 : 2'b00;
                chk($sformatf("alt_%0d", j), bus.trigger_o, e);
            end
        end

        // Random stream with random threshold staging.
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 8; ch++)
                for (int s = 0; s < 8; s++)
                    rd[ch][5*s +: 5] = 5'($urandom_range(0, 31));
            step(rd, 18'($urandom_range(0, 12000)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beamform_power_trigger.md
Name: beamform_power_trigger

Overview:
- Per-beam delay-and-sum beamformer and power threshold trigger for the L1 path.
- Consumes 8 channels of 5-bit AGC-scaled samples, 8 samples per clock.
- Forms NBEAMS fixed-delay beams and computes the 8-sample power of each beam every clock.
- Asserts one trigger bit per beam when that power exceeds the beam's programmable 18-bit threshold.

Parameters:
- NBEAMS, 2, number of beams.
- BEAM_DELAYS, 64'h76543210_00000000, packed [NBEAMS-1:0][7:0][3:0] per-beam, per-channel delay in samples (0..15). Channel 0 is the LSB nibble of each beam's 32-bit group. Default: beam0 all delays 0; beam1 delay[ch]=ch.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  [7:0][39:0]  per channel, 8 samples of 5-bit two's complement. Bits [5s+4:5s] hold sample s; s=0 is oldest.
- thresh_i  in  18  threshold value to stage.
- thresh_ce_i  in  NBEAMS  per-beam stage strobe.
- update_i  in  1  copies all staged thresholds to active.
- trigger_o  out  NBEAMS  registered per-beam trigger.

Behaviour:
- Reset, asynchronous while rst_ni=0:
  - trigger_o=0.
  - All pipeline and history registers = 0.
  - Staged and active thresholds = 18'h3FFFF, so no trigger is possible.
- Stream model: x_ch[t] with t=8n+s for clock n. The bench keeps the previous 2 clocks (16 samples) of history per channel; history before reset release is 0.
- Beam sum at sample t: B_b[t] = sum over ch of x_ch[t - BEAM_DELAYS[b][ch]]. Signed 8-bit, range -128..120, no saturation.
- Square: B_b[t]^2, unsigned 15-bit, max 16384.
- Power for clock n: P_b[n] = sum of the 8 squares for s=0..7 of clock n. Unsigned 18-bit, max 131072, never overflows.
- Trigger: trigger_o[b] = (P_b[n] > active_thresh[b]), strictly greater. Equality does not trigger.
- Latency: exactly 4 clocks. Samples presented at edge N produce trigger_o after edge N+4.
  - Pipeline stages: beam sums, squares, power, compare/register.
  - The compare uses the active threshold as registered at the compare edge.
  - Throughput is one evaluation per clock; trigger_o is re-evaluated every clock with no internal holdoff.
- Threshold staging:
  - On an edge with thresh_ce_i[b]=1: staged[b] <= thresh_i. Several bits may be set at once; all those beams load.
  - On an edge with update_i=1: active[b] <= staged[b] for every b.
  - When thresh_ce_i and update_i are high on the same edge, update transfers the staged value held before that edge. The new staged value takes effect only on a later update.
  - thresh_ce_i without update_i never changes the active threshold.
- Reset mid-operation: outputs clear immediately and asynchronously. Thresholds return to 18'h3FFFF. Operation resumes on the first edge after rst_ni rises, with zero history.
- Pipeline holds no X after reset. The pipeline must be fully registered so that 375 MHz timing is feasible; adder trees may be split internally only if the external 4-clock latency is preserved.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with triggers active -> trigger_o=0 at once. After release, all-zero data with threshold 0 loaded and updated -> trigger_o stays 0 (power 0 is not >0).
- Constant data: every sample =1 on all channels; stage 100 into beam0 (thresh_ce_i=2'b01) then update_i -> after 4 clocks and steady state, trigger_o=2'b01 (P=512 on both beams; beam1 still at 3FFFF).
- Boundary: same data, active threshold 512 -> trigger_o[0]=0. Threshold 511 -> trigger_o[0]=1. Data -16 everywhere, threshold 131071 -> triggers (P=131072).
- Staging: stage 0 into beam1 without update -> trigger_o[1] unchanged. Pulse thresh_ce_i and update_i together with a new value -> old staged value becomes active; a following update loads the new value.
- Delay alignment: one clock with channel ch carrying value 1 at sample 7-ch (else 0); both thresholds 32 -> beam1 power 64 triggers, beam0 power 8 does not. Exactly one trigger_o[1] pulse, 4 clocks after the input clock.
- Latency and throughput: alternate high and zero-power clocks -> trigger_o toggles every clock with 4-clock delay.
